adc081s101_emu: RTL and testbench
=================================

Name: adc081s101_emu

Overview:
- Cycle-accurate responder model of the ADC081S101 serial interface, i.e. the other end of the adc081s101 receiver.
- Drives MISO frames into the pixel ADC inputs from an external sample value or a built-in pattern generator.
- Used for FPGA loopback and bring-up of the stonyman capture and FIFO chain without a sensor attached.
- Runs on the same clk that is exported as px_adc_sclk, so one frame bit is presented per clk cycle while cs is low.

Parameters:
- FRAME_BITS, 16, clocks per conversion frame; must be ≥ 3 + 8.
- LEAD_ZEROS, 3, leading zero bits before D7.
- CONST_VALUE, 8'hFF, sample used in mode 2'b11.
- RAMP_STEP, 8'd1, ramp increment per completed frame.

Ports:
- clk  in  1  system clock; the same net that drives px_adc_sclk.
- reset  in  1  synchronous, active-low reset.
- cs  in  1  chip select from the receiver, active-low.
- mode  in  2  data source: 00 = sample_in, 01 = ramp, 10 = alternating 8'h55/8'hAA, 11 = CONST_VALUE.
- sample_in  in  8  external sample, latched at frame start.
- miso  out  1  serial data to the receiver's miso input.
- miso_oe  out  1  high while a frame is being driven (tri-state enable for pad use).
- busy  out  1  high from frame start until the end of the frame or an abort.
- frame_done  out  1  one-cycle pulse when a full frame completes.
- frame_abort  out  1  one-cycle pulse when cs rises mid-frame.
- last_sample  out  8  value sent in the most recent started frame.
- frame_count  out  16  count of completed frames; wraps 16'hFFFF→0.

Behaviour:
- All state updates on rising clk. Reset is synchronous: when reset==0 at an edge, every register is cleared on that edge.
- Reset values:
  - miso=0, miso_oe=0, busy=0, frame_done=0, frame_abort=0, last_sample=0, frame_count=0.
  - cs_q=1, ramp=0, alt toggle=0, state=IDLE.
- cs_q holds cs registered by one cycle. A frame start is detected at any edge where cs==0 and cs_q==1.
- State IDLE:
  - On frame start: latch word = source(mode), set last_sample=word, bitcnt=0, busy=1, miso_oe=1, miso=frame bit 0, go to SHIFT.
  - Otherwise miso=0, miso_oe=0.
- Frame bit k:
  - 0 for k < LEAD_ZEROS.
  - word[7-(k-LEAD_ZEROS)] for LEAD_ZEROS ≤ k < LEAD_ZEROS+8 (MSB first).
  - 0 for the remaining bits up to FRAME_BITS-1.
- Timing: miso for bit k is registered on the (k+1)-th edge after cs is first sampled low, and holds for one cycle.
- State SHIFT, cs==0:
  - bitcnt increments and miso = frame bit bitcnt+1.
  - On the edge after bit FRAME_BITS-1 has been driven: frame_done=1 for one cycle, frame_count+1, busy=0, advance pattern state, go to HOLD.
- State HOLD (cs still low after a complete frame): miso=0, miso_oe=1, busy=0. No new frame starts until cs has been seen high.
- cs==1 in SHIFT (abort):
  - On that edge: frame_abort=1 for one cycle, busy=0, miso=0, miso_oe=0, go to IDLE.
  - frame_count unchanged and pattern state not advanced.
- cs==1 in HOLD: go to IDLE, miso_oe=0.
- Pattern rules:
  - Ramp: ramp += RAMP_STEP modulo 256, only on a completed frame while mode==01.
  - Alternate: alt toggles on each completed frame while mode==10; 55 is sent when alt=0, AA when alt=1.
  - mode is sampled only at frame start; a change mid-frame takes effect on the next frame.
- Simultaneous events:
  - cs falling on the same edge that HOLD→IDLE would occur cannot happen, because cs must be high for at least one cycle.
  - A cs pulse high for exactly one cycle between frames is legal and starts a new frame.
- reset asserted mid-frame: outputs go to their reset values on that edge. No frame_done or frame_abort pulse is generated.
- Latency: frame start to first data bit (D7) on miso is LEAD_ZEROS+1 edges. frame_done occurs FRAME_BITS+1 edges after cs is first sampled low.

Test Plan:
- mode=00, sample_in=8'hA5, cs low for 17 cycles → miso sequence 000 1010 0101 00000; frame_done pulses once; frame_count=1; last_sample=A5.
- mode=01, 4 back-to-back frames with cs high 1 cycle between them → samples 00,01,02,03; frame_count=4; ramp=04.
- mode=10, cs raised at bit 6 of the 2nd frame → frame_abort pulses once; frame_count=1; the 3rd frame sends AA (pattern not advanced).
- Connect to adc081s101 with startCapture pulses, mode=11 → receiver dataout=FF and conversionComplete asserted each frame.
- reset driven low at bit 8 of a frame → next edge: miso=0, miso_oe=0, busy=0, frame_count=0, no pulses; a following frame with mode=01 sends 00.
- Preload frame_count to FFFF via 65535 frames (or force) and complete one more frame → frame_count=0000.

Source files
------------

// File: rtl/adc081s101_emu_if.sv
// Serial link between an ADC081S101 receiver and the emulator.
//   cs      : chip select, active-low, driven by the receiver
//   miso    : serial frame data, driven by the emulator
//   miso_oe : pad output enable for miso, driven by the emulator
// The master modport is the receiver side and the slave modport is the emulator side.
interface adc081s101_emu_if;
  logic cs;
  logic miso;
  logic miso_oe;

  modport master (output cs, input miso, input miso_oe);
  modport slave  (input cs, output miso, output miso_oe);
endinterface

// File: rtl/adc081s101_emu.sv
// Cycle-accurate responder model of the ADC081S101 serial interface.
// It sends one frame bit per clk while cs is low, so clk is the same net as the
// receiver's sclk. Each frame is LEAD_ZEROS zeros, then the 8-bit sample MSB first,
// then zeros up to FRAME_BITS.
// Ports:
//   clk          system clock, also exported as the ADC sclk
//   reset        synchronous, active-low reset
//   bus          serial link (cs in; miso and miso_oe out)
//   mode         data source: 00 sample_in, 01 ramp, 10 alternating 55/AA, 11 CONST_VALUE
//   sample_in    external sample, latched at frame start
//   busy         high from frame start until the frame completes or aborts
//   frame_done   one-cycle pulse when a full frame completes
//   frame_abort  one-cycle pulse when cs rises mid-frame
//   last_sample  value sent in the most recently started frame
//   frame_count  number of completed frames, wraps at 16 bits
// FRAME_BITS must be at least LEAD_ZEROS + 8.
module adc081s101_emu #(
  parameter int         FRAME_BITS  = 16,
  parameter int         LEAD_ZEROS  = 3,
  parameter logic [7:0] CONST_VALUE = 8'hFF,
  parameter logic [7:0] RAMP_STEP   = 8'd1
) (
  input  logic        clk,
  input  logic        reset,
  adc081s101_emu_if.slave bus,
  input  logic [1:0]  mode,
  input  logic [7:0]  sample_in,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [7:0]  last_sample,
  output logic [15:0] frame_count
);

  localparam int CW = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t        state, state_next;
  logic          cs_q;
  logic [CW-1:0] bitcnt, bitcnt_next;
  logic [7:0]    word, word_next;
  logic [1:0]    frame_mode, frame_mode_next;
  logic [7:0]    ramp, ramp_next;
  logic          alt, alt_next;
  logic          miso_next, miso_oe_next;
  logic          busy_next, done_next, abort_next;
  logic [7:0]    last_next;
  logic [15:0]   count_next;
  logic [7:0]    source;
  logic          frame_start;

  // Returns frame bit k for data word w: leading zeros, then w MSB first, then zeros.
  function automatic logic frame_bit(input int k, input logic [7:0] w);
    logic [7:0] sh;
    sh = w;
    frame_bit = 1'b0;
    if (k >= LEAD_ZEROS && k < LEAD_ZEROS + 8) begin
      sh = w << (k - LEAD_ZEROS);
      frame_bit = sh[7];
    end
  endfunction

  // A new frame needs cs to have been seen high first, so a frame that is held
  // low after completion never restarts on its own.
  assign frame_start = !bus.cs && cs_q;

  always_comb begin
    source = sample_in;
    case (mode)
      2'b00: source = sample_in;
      2'b01: source = ramp;
      2'b10: source = alt ? 8'hAA : 8'h55;
      2'b11: source = CONST_VALUE;
      default: source = sample_in;
    endcase
  end

  always_comb begin
    state_next      = state;
    bitcnt_next     = bitcnt;
    word_next       = word;
    frame_mode_next = frame_mode;
    ramp_next       = ramp;
    alt_next        = alt;
    miso_next       = 1'b0;
    miso_oe_next    = bus.miso_oe;
    busy_next       = busy;
    done_next       = 1'b0;
    abort_next      = 1'b0;
    last_next       = last_sample;
    count_next      = frame_count;

    case (state)
      IDLE: begin
        miso_oe_next = 1'b0;
        busy_next    = 1'b0;
        if (frame_start) begin
          word_next       = source;
          frame_mode_next = mode;
          last_next       = source;
          bitcnt_next     = '0;
          busy_next       = 1'b1;
          miso_oe_next    = 1'b1;
          miso_next       = frame_bit(0, source);
          state_next      = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.cs) begin
          abort_next   = 1'b1;
          busy_next    = 1'b0;
          miso_oe_next = 1'b0;
          state_next   = IDLE;
        end else if (int'(bitcnt) == FRAME_BITS - 1) begin
          // Pattern state only advances on a completed frame, using the mode
          // that was latched when this frame started.
          done_next    = 1'b1;
          count_next   = frame_count + 16'd1;
          busy_next    = 1'b0;
          miso_oe_next = 1'b1;
          if (frame_mode == 2'b01) ramp_next = ramp + RAMP_STEP;
          if (frame_mode == 2'b10) alt_next = ~alt;
          state_next   = HOLD;
        end else begin
          bitcnt_next = bitcnt + CW'(1);
          miso_next   = frame_bit(int'(bitcnt) + 1, word);
        end
      end

      HOLD: begin
        miso_oe_next = 1'b1;
        busy_next    = 1'b0;
        if (bus.cs) begin
          miso_oe_next = 1'b0;
          state_next   = IDLE;
        end
      end

      default: begin
        miso_oe_next = 1'b0;
        busy_next    = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cs_q        <= 1'b1;
      bitcnt      <= '0;
      word        <= '0;
      frame_mode  <= '0;
      ramp        <= '0;
      alt         <= 1'b0;
      bus.miso    <= 1'b0;
      bus.miso_oe <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      last_sample <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_next;
      cs_q        <= bus.cs;
      bitcnt      <= bitcnt_next;
      word        <= word_next;
      frame_mode  <= frame_mode_next;
      ramp        <= ramp_next;
      alt         <= alt_next;
      bus.miso    <= miso_next;
      bus.miso_oe <= miso_oe_next;
      busy        <= busy_next;
      frame_done  <= done_next;
      frame_abort <= abort_next;
      last_sample <= last_next;
      frame_count <= count_next;
    end
  end

endmodule

// File: tb/tb_adc081s101_emu.sv
// Testbench for adc081s101_emu with default parameters (16-bit frames, 3 leading zeros).
// Expected frames are pushed to a scoreboard queue when a frame is launched and
// popped when the DUT signals frame_done.
module tb_adc081s101_emu;

  logic        clk;
  logic        reset;
  logic [1:0]  mode;
  logic [7:0]  sample_in;
  logic        busy;
  logic        frame_done;
  logic        frame_abort;
  logic [7:0]  last_sample;
  logic [15:0] frame_count;

  adc081s101_emu_if bus_if();

  adc081s101_emu dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if.slave),
    .mode        (mode),
    .sample_in   (sample_in),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .last_sample (last_sample),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  ramp_m   = 8'd0;
  logic        alt_m    = 1'b0;
  logic [15:0] fc_m     = 16'd0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] modelSource(input logic [1:0] m, input logic [7:0] s);
    case (m)
      2'b00:   return s;
      2'b01:   return ramp_m;
      2'b10:   return alt_m ? 8'hAA : 8'h55;
      default: return 8'hFF;
    endcase
  endfunction

  // Frame image with bit 0 in the MSB position.
  function automatic logic [15:0] frameOf(input logic [7:0] w);
    return {3'b000, w, 5'b00000};
  endfunction

  // One complete frame; mode and sample_in are scrambled mid-frame to show they are
  // only sampled at frame start. hold_extra keeps cs low after completion.
  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] s, input int hold_extra);
    logic [7:0]  w;
    logic [15:0] cap;
    w   = modelSource(m, s);
    cap = '0;
    @(negedge clk);
    mode = m;
    sample_in = s;
    bus_if.cs = 1'b0;
    exp_q.push_back(frameOf(w));
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      cap[15-k] = bus_if.miso;
      if (k == 0) begin
        checkOutput("busy_start", busy, 1);
        checkOutput("oe_start", bus_if.miso_oe, 1);
        checkOutput("last_sample", last_sample, w);
      end
      if (k == 4) begin
        mode = ~m;
        sample_in = ~s;
      end
    end
    @(posedge clk); #1;
    checkOutput("frame_done", frame_done, 1);
    checkOutput("busy_done", busy, 0);
    fc_m = fc_m + 16'd1;
    if (m == 2'b01) ramp_m = ramp_m + 8'd1;
    if (m == 2'b10) alt_m = ~alt_m;
    checkOutput("frame_count", frame_count, fc_m);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue expected entry");
    end else begin
      checkOutput("frame_bits", cap, exp_q.pop_front());
    end
    for (int h = 0; h < hold_extra; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_oe", bus_if.miso_oe, 1);
      checkOutput("hold_miso", bus_if.miso, 0);
      checkOutput("hold_done", frame_done, 0);
      checkOutput("hold_busy", busy, 0);
    end
    @(negedge clk);
    bus_if.cs = 1'b1;
    mode = m;
    sample_in = s;
  endtask

  // Frame aborted by raising cs once bit abort_bit has been driven.
  task automatic abortFrame(input logic [1:0] m, input logic [7:0] s, input int abort_bit);
    logic [7:0]  w;
    logic [15:0] cap;
    w   = modelSource(m, s);
    cap = '0;
    @(negedge clk);
    mode = m;
    sample_in = s;
    bus_if.cs = 1'b0;
    for (int k = 0; k <= abort_bit; k++) begin
      @(posedge clk); #1;
      cap[15-k] = bus_if.miso;
    end
    @(negedge clk);
    bus_if.cs = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_pulse", frame_abort, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_oe", bus_if.miso_oe, 0);
    checkOutput("abort_miso", bus_if.miso, 0);
    checkOutput("abort_count", frame_count, fc_m);
    checkOutput("abort_bits", cap >> (15 - abort_bit), frameOf(w) >> (15 - abort_bit));
    @(posedge clk); #1;
    checkOutput("abort_once", frame_abort, 0);
  endtask

  // Reset pulled low once bit reset_bit has been driven.
  task automatic resetMidFrame(input logic [1:0] m, input int reset_bit);
    @(negedge clk);
    mode = m;
    bus_if.cs = 1'b0;
    for (int k = 0; k <= reset_bit; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_miso", bus_if.miso, 0);
    checkOutput("rst_oe", bus_if.miso_oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", frame_count, 0);
    checkOutput("rst_done", frame_done, 0);
    checkOutput("rst_abort", frame_abort, 0);
    @(negedge clk);
    reset = 1'b1;
    bus_if.cs = 1'b1;
    ramp_m = 8'd0;
    alt_m  = 1'b0;
    fc_m   = 16'd0;
  endtask

  initial begin
    reset = 1'b0;
    bus_if.cs = 1'b1;
    mode = 2'b00;
    sample_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_miso", bus_if.miso, 0);
    checkOutput("reset_oe", bus_if.miso_oe, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", frame_done, 0);
    checkOutput("reset_abort", frame_abort, 0);
    checkOutput("reset_last", last_sample, 0);
    checkOutput("reset_count", frame_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] external sample frame");
    applyStimulus(2'b00, 8'hA5, 0);

    $display("[TB] ramp frames back to back");
    for (int i = 0; i < 5; i++) applyStimulus(2'b01, 8'h3C, 0);

    $display("[TB] alternating pattern with abort");
    applyStimulus(2'b10, 8'h00, 0);
    abortFrame(2'b10, 8'h00, 6);
    applyStimulus(2'b10, 8'h00, 0);
    applyStimulus(2'b10, 8'h00, 0);

    $display("[TB] constant frame with hold");
    applyStimulus(2'b11, 8'h12, 3);

    $display("[TB] reset mid-frame");
    resetMidFrame(2'b10, 8);
    applyStimulus(2'b01, 8'h00, 0);

    $display("[TB] frame counter wrap");
    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    fc_m = 16'hFFFF;
    applyStimulus(2'b00, 8'h81, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
